// File: rtl/nphase_generator_if.sv
// LO control/status bundle for nphase_generator: run/prescale/sideband controls in,
// one-hot switch enables and status out.
interface nphase_generator_if #(
    parameter int unsigned PHASES = 4,
    parameter int unsigned DIV_W  = 4,
    parameter int unsigned IDX_W  = (PHASES > 1) ? $clog2(PHASES) : 1
);
    logic              enable;
    logic [DIV_W-1:0]  div;
    logic              reverse;
    logic [PHASES-1:0] phase_out;
    logic [IDX_W-1:0]  phase_idx;
    logic              cycle_strobe;
    logic              running;

    modport master (
        output enable, div, reverse,
        input  phase_out, phase_idx, cycle_strobe, running
    );

    modport slave (
        input  enable, div, reverse,
        output phase_out, phase_idx, cycle_strobe, running
    );
endinterface

// File: rtl/nphase_generator.sv
// Multi-phase one-hot LO generator with prescaler, sideband reversal and clean start/stop.
// Optional break-before-make dead time: define NPHASE_DEADTIME_EN.
module nphase_generator #(
    parameter int unsigned PHASES = 4,
    parameter int unsigned DIV_W  = 4
) (
    input logic             if_clk,
    input logic             if_rst,
    nphase_generator_if.slave lo
);
    localparam int unsigned IDX_W = (PHASES > 1) ? $clog2(PHASES) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  pre_cnt, pre_nxt;
    logic [DIV_W-1:0]  div_act, div_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [IDX_W-1:0]  step_idx;
    logic              rev_act, rev_nxt;
    logic              strobe_nxt;
    logic [PHASES-1:0] phase_nxt;
    logic [PHASES-1:0] phase_q;
    logic              strobe_q;
    logic              running_q;

    always_ff @(posedge if_clk) begin
        if (if_rst) begin
            state     <= IDLE;
            pre_cnt   <= '0;
            idx       <= '0;
            div_act   <= '0;
            rev_act   <= 1'b0;
            phase_q   <= '0;
            strobe_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            pre_cnt   <= pre_nxt;
            idx       <= idx_nxt;
            div_act   <= div_nxt;
            rev_act   <= rev_nxt;
            phase_q   <= phase_nxt;
            strobe_q  <= strobe_nxt;
            running_q <= (state_nxt == RUN);
        end
    end

    always_comb begin
        state_nxt  = state;
        pre_nxt    = pre_cnt;
        idx_nxt    = idx;
        div_nxt    = div_act;
        rev_nxt    = rev_act;
        strobe_nxt = 1'b0;
        phase_nxt  = '0;
        // Power-of-two PHASES lets the index wrap naturally in IDX_W bits.
        step_idx   = rev_act ? (idx - 1'b1) : (idx + 1'b1);

        case (state)
            IDLE: begin
                if (lo.enable) begin
                    state_nxt  = RUN;
                    pre_nxt    = '0;
                    idx_nxt    = '0;
                    div_nxt    = lo.div;
                    rev_nxt    = lo.reverse;
                    strobe_nxt = 1'b1;
                end
            end
            RUN: begin
                if (pre_cnt != div_act) begin
                    pre_nxt = pre_cnt + 1'b1;
                end else begin
                    pre_nxt = '0;
                    if (step_idx != '0) begin
                        idx_nxt = step_idx;
                    end else if (lo.enable) begin
                        idx_nxt    = '0;
                        div_nxt    = lo.div;
                        rev_nxt    = lo.reverse;
                        strobe_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == RUN) begin
            phase_nxt[idx_nxt] = 1'b1;
        end
`ifdef NPHASE_DEADTIME_EN
        if (div_nxt != '0 && pre_nxt == '0) begin
            phase_nxt = '0;
        end
`endif
    end

    assign lo.phase_out    = phase_q;
    assign lo.phase_idx    = idx;
    assign lo.cycle_strobe = strobe_q;
    assign lo.running      = running_q;
endmodule
